// File: rtl/multicycle_adder.sv
// multicycle_adder: adds or subtracts two WIDTH-bit operands CHUNK bits per cycle.
// An operand set is accepted on a valid/ready handshake, processed over NCH = WIDTH/CHUNK
// compute cycles, and the registered result is held until the consumer takes it.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present on X, Y, cin, sub
//   in_ready   block can accept an operand set this cycle
//   X, Y       operands
//   cin        carry-in for add mode (ignored when sub=1)
//   sub        0: X+Y+cin, 1: X-Y (X+~Y+1)
//   out_valid  S, Cout, Ovf hold a valid result
//   out_ready  consumer accepts the result this cycle
//   S          registered sum/difference
//   Cout       carry out of the MSB (for sub, 1 means no borrow)
//   Ovf        two's-complement overflow
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;
    logic             accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

    always_comb begin
        base      = 32'(idx_q) * 32'(CHUNK);
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c_in.
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: ;
            CALC: begin
                s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d            = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept is only possible in IDLE or in DONE with out_ready, so it overrides
        // the per-state decisions above; from DONE this gives back-to-back operation.
        if (accept) begin
            a_d     = X;
            b_d     = Y ^ {WIDTH{sub}};
            carry_d = sub | cin;
            idx_d   = '0;
            state_d = CALC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
module tb_multicycle_adder;

    typedef struct {
        string      name;
        logic [7:0] x;
        logic [7:0] y;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] X, Y;
    logic       cin, sub;

    logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, cout_a, ovf_a;
    logic [7:0] s_a;
    logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, cout_b, ovf_b;
    logic [7:0] s_b;

    // Selects which instance the shared tasks observe/drive.
    logic       b_sel = 1'b0;
    logic       m_in_ready, m_out_valid, m_cout, m_ovf;
    logic [7:0] m_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        m_in_ready  = b_sel ? in_ready_b  : in_ready_a;
        m_out_valid = b_sel ? out_valid_b : out_valid_a;
        m_cout      = b_sel ? cout_b      : cout_a;
        m_ovf       = b_sel ? ovf_b       : ovf_a;
        m_s         = b_sel ? s_b         : s_a;
    end

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .X(X), .Y(Y), .cin(cin), .sub(sub), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .S(s_a), .Cout(cout_a), .Ovf(ovf_a)
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .X(X), .Y(Y), .cin(cin), .sub(sub), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .S(s_b), .Cout(cout_b), .Ovf(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in_valid(input logic v);
        if (b_sel) in_valid_b = v;
        else       in_valid_a = v;
    endtask

    task automatic set_out_ready(input logic v);
        if (b_sel) out_ready_b = v;
        else       out_ready_a = v;
    endtask

    // Counts rising edges until out_valid, bounded at 20.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!m_out_valid && lat < 20);
    endtask

    task automatic run_op(input vec_t v, input int exp_lat);
        int lat;
        @(negedge clk);
        X = v.x; Y = v.y; cin = v.cin; sub = v.sub;
        set_in_valid(1'b1);
        chk({v.name, " in_ready"}, 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        set_in_valid(1'b0);
        // Operand changes after accept must not disturb the result.
        X = 8'($urandom); Y = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        wait_valid(lat);
        chk({v.name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({v.name, " S"}, 32'(m_s), 32'(v.s));
        chk({v.name, " Cout"}, 32'(m_cout), 32'(v.cout));
        chk({v.name, " Ovf"}, 32'(m_ovf), 32'(v.ovf));
        @(negedge clk);
        set_out_ready(1'b1);
        @(posedge clk);
        #1;
        set_out_ready(1'b0);
        chk({v.name, " out_valid drop"}, 32'(m_out_valid), 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{"add_carry",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{"ovf_pos",     8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{"sub_neg",     8'h80, 8'hFF, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[3]  = '{"sub_borrow",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{"add_10_20",   8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[5]  = '{"add_3_4",     8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[6]  = '{"ff_ff_cin",   8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7]  = '{"ovf_neg",     8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{"zero_cin",    8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{"55_aa_cin",   8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{"sub_0_1",     8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid_a = 1'b0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0;
        X = 8'h00; Y = 8'h00; cin = 1'b0; sub = 1'b0;
        #2;
        chk("rst S", 32'(s_a), 32'h0);
        chk("rst Cout", 32'(cout_a), 32'h0);
        chk("rst Ovf", 32'(ovf_a), 32'h0);
        chk("rst out_valid", 32'(out_valid_a), 32'h0);
        chk("rst in_ready", 32'(in_ready_a), 32'h1);

        // Release just after a rising edge so the first op lands on the next one.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        b_sel = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], 4);
        end

        // Single-chunk instance: same results at latency 1.
        b_sel = 1'b1;
        run_op(vecs[0], 1);
        run_op(vecs[1], 1);
        run_op(vecs[3], 1);
        b_sel = 1'b0;

        // Backpressure, then back-to-back accept from DONE.
        @(negedge clk);
        X = 8'h12; Y = 8'h34; cin = 1'b0; sub = 1'b0;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        wait_valid(lat);
        chk("bp latency", 32'(lat), 32'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp hold out_valid", 32'(out_valid_a), 32'd1);
            chk("bp hold S", 32'(s_a), 32'h46);
            chk("bp hold Cout", 32'(cout_a), 32'd0);
            chk("bp hold Ovf", 32'(ovf_a), 32'd0);
            chk("bp hold in_ready", 32'(in_ready_a), 32'd0);
        end
        out_ready_a = 1'b1;
        in_valid_a = 1'b1;
        X = 8'h10; Y = 8'h20; cin = 1'b0; sub = 1'b0;
        #1 chk("b2b in_ready", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b out_valid next", 32'(out_valid_a), 32'd0);
        in_valid_a = 1'b0; out_ready_a = 1'b0;
        X = 8'hAA; Y = 8'h55;
        wait_valid(lat);
        chk("b2b latency", 32'(lat), 32'd4);
        chk("b2b S", 32'(s_a), 32'h30);
        @(negedge clk) out_ready_a = 1'b1;
        @(posedge clk);
        #1 out_ready_a = 1'b0;

        // Abort: reset two cycles after accept.
        @(negedge clk);
        X = 8'hFF; Y = 8'hFF; cin = 1'b1; sub = 1'b0;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort S", 32'(s_a), 32'h0);
        chk("abort Cout", 32'(cout_a), 32'd0);
        chk("abort Ovf", 32'(ovf_a), 32'd0);
        chk("abort out_valid", 32'(out_valid_a), 32'd0);
        chk("abort in_ready", 32'(in_ready_a), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (out_valid_a) seen++;
        end
        chk("abort no out_valid", 32'(seen), 32'd0);
        run_op(vecs[5], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
